// File: rtl/cpu_mem_resp.sv
// CPU-bus memory responder: side-loaded ROM, RAM and a status register behind one 13-bit address bus.
// Read data goes onto the bus READ_LAT cycles after a read strobe and stays there until the strobe drops.
module cpu_mem_resp #(
    parameter int ROM_AW   = 8,
    parameter int RAM_AW   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [12:0]       addr,
    inout  wire  [7:0]        data,
    input  logic              halt,
    input  logic              ld_en,
    input  logic [ROM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,
    output logic              data_oe,
    output logic              rom_wr_err,
    output logic [15:0]       halt_cycles
);

    // state  | meaning
    // IDLE   | no read in progress, bus released
    // WAIT   | read launched, counting down the latency
    // DRIVE  | read data registered and driven while rd stays high
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRIVE} state_t;

    localparam logic [12:0] STATUS_ADDR = 13'h1FFF;
    localparam logic [1:0]  LAT_INIT    = 2'(READ_LAT - 1);

    logic [7:0] rom_mem [2**ROM_AW];
    logic [7:0] ram_mem [2**RAM_AW];

    state_t      state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic [12:0] raddr_q, raddr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        data_oe_q, data_oe_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        conflict_q, conflict_d;
    logic [12:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [6:0]  err_cnt_q, err_cnt_d;
    logic        halt_seen_q, halt_seen_d;
    logic [15:0] halt_cycles_q, halt_cycles_d;
    logic        ld_ack_q, ld_ack_d;
    logic        rom_wr_err_q, rom_wr_err_d;

    logic       conflict;
    logic       wr_commit;
    logic       wr_ram;
    logic       wr_rom;
    logic       wr_status;
    logic       err_inc;
    logic       ld_accept;
    logic [7:0] rd_byte;

    assign conflict  = rd && wr;
    assign wr_commit = wr_q && !wr;
    assign wr_status = wr_commit && (wr_addr_q == STATUS_ADDR);
    assign wr_ram    = wr_commit && wr_addr_q[12] && (wr_addr_q != STATUS_ADDR);
    assign wr_rom    = wr_commit && !wr_addr_q[12];
    assign err_inc   = wr_rom || (conflict && !conflict_q);
    // ld_ack_q blocks a second accept in the cycle the requester is still dropping ld_en
    assign ld_accept = ld_en && !rd && !wr && !ld_ack_q;

    always_comb begin
        rd_byte = 8'h00;
        if (raddr_q == STATUS_ADDR) begin
            rd_byte = {halt_seen_q, err_cnt_q};
        end else if (raddr_q[12]) begin
            rd_byte = ram_mem[raddr_q[RAM_AW-1:0]];
        end else if ((raddr_q[11:0] >> ROM_AW) == 12'd0) begin
            rd_byte = rom_mem[raddr_q[ROM_AW-1:0]];
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        data_oe_d = data_oe_q;
        case (state_q)
            ST_IDLE: begin
                if (rd && !wr && !rd_q) begin
                    state_d = ST_WAIT;
                    raddr_d = addr;
                    lat_d   = LAT_INIT;
                end
            end
            ST_WAIT: begin
                if (conflict || !rd) begin
                    state_d = ST_IDLE;
                end else if (addr != raddr_q) begin
                    raddr_d = addr;
                    lat_d   = LAT_INIT;
                end else if (lat_q == 2'd0) begin
                    rdata_d   = rd_byte;
                    data_oe_d = 1'b1;
                    state_d   = ST_DRIVE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_DRIVE: begin
                if (conflict || !rd) begin
                    state_d   = ST_IDLE;
                    data_oe_d = 1'b0;
                end else if (addr != raddr_q) begin
                    state_d   = ST_WAIT;
                    raddr_d   = addr;
                    lat_d     = LAT_INIT;
                    data_oe_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                data_oe_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_d          = rd;
        wr_d          = wr;
        conflict_d    = conflict;
        wr_addr_d     = wr ? addr : wr_addr_q;
        wr_data_d     = wr ? data : wr_data_q;
        ld_ack_d      = ld_accept;
        rom_wr_err_d  = wr_rom;
        err_cnt_d     = err_cnt_q;
        halt_cycles_d = halt_cycles_q;
        halt_seen_d   = halt_seen_q | halt;
        // a STATUS write wins over any increment in the same cycle
        if (wr_status) begin
            err_cnt_d   = 7'd0;
            halt_seen_d = 1'b0;
        end else if (err_inc && (err_cnt_q != 7'h7F)) begin
            err_cnt_d = err_cnt_q + 7'd1;
        end
        if (halt && (halt_cycles_q != 16'hFFFF)) begin
            halt_cycles_d = halt_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            lat_q         <= 2'd0;
            raddr_q       <= 13'd0;
            rdata_q       <= 8'h00;
            data_oe_q     <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            conflict_q    <= 1'b0;
            wr_addr_q     <= 13'd0;
            wr_data_q     <= 8'h00;
            err_cnt_q     <= 7'd0;
            halt_seen_q   <= 1'b0;
            halt_cycles_q <= 16'd0;
            ld_ack_q      <= 1'b0;
            rom_wr_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            raddr_q       <= raddr_d;
            rdata_q       <= rdata_d;
            data_oe_q     <= data_oe_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            conflict_q    <= conflict_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            err_cnt_q     <= err_cnt_d;
            halt_seen_q   <= halt_seen_d;
            halt_cycles_q <= halt_cycles_d;
            ld_ack_q      <= ld_ack_d;
            rom_wr_err_q  <= rom_wr_err_d;
        end
    end

    // memory contents survive reset
    always_ff @(posedge clk) begin
        if (ld_accept) begin
            rom_mem[ld_addr] <= ld_data;
        end
        if (wr_ram) begin
            ram_mem[wr_addr_q[RAM_AW-1:0]] <= wr_data_q;
        end
    end

    assign data        = (data_oe_q && rd) ? rdata_q : 8'hzz;
    assign data_oe     = data_oe_q;
    assign ld_ack      = ld_ack_q;
    assign rom_wr_err  = rom_wr_err_q;
    assign halt_cycles = halt_cycles_q;

endmodule

// File: tb/tb_cpu_mem_resp.sv
// Bench for cpu_mem_resp: read data is checked against a scoreboard queue filled when each read is issued.
module tb_cpu_mem_resp;

    localparam int ROM_AW   = 8;
    localparam int RAM_AW   = 8;
    localparam int READ_LAT = 2;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              rd       = 1'b0;
    logic              wr       = 1'b0;
    logic              halt     = 1'b0;
    logic              ld_en    = 1'b0;
    logic [12:0]       addr     = 13'd0;
    logic [ROM_AW-1:0] ld_addr  = '0;
    logic [7:0]        ld_data  = 8'h00;
    logic [7:0]        drv_data = 8'h00;
    logic              drv_en   = 1'b0;
    wire  [7:0]        data;
    logic              ld_ack;
    logic              data_oe;
    logic              rom_wr_err;
    logic [15:0]       halt_cycles;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    assign data = drv_en ? drv_data : 8'hzz;

    always #5 clk = ~clk;

    cpu_mem_resp #(
        .ROM_AW  (ROM_AW),
        .RAM_AW  (RAM_AW),
        .READ_LAT(READ_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .data       (data),
        .halt       (halt),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ack     (ld_ack),
        .data_oe    (data_oe),
        .rom_wr_err (rom_wr_err),
        .halt_cycles(halt_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // a released bus reads as Z on four-state simulators and as 0 on two-state ones
    function automatic bit bus_free();
        return (data === 8'hzz) || (data === 8'h00);
    endfunction

    task automatic cpu_read(input logic [12:0] a, input logic [7:0] exp, input string nm);
        int n;
        logic [7:0] want;
        exp_q.push_back(exp);
        addr = a;
        rd   = 1'b1;
        for (n = 1; n <= READ_LAT + 4; n++) begin
            step();
            if (data_oe === 1'b1) break;
            vectors++;
            if (!bus_free()) begin
                miscompares++;
                $display("FAIL %s early_drive: data=%h before oe, want released", nm, data);
            end
        end
        want = exp_q.pop_front();
        vectors++;
        if (n != READ_LAT + 1 || data_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL %s latency: oe after %0d cycles (oe=%b), want %0d", nm, n, data_oe, READ_LAT + 1);
        end
        vectors++;
        if (data !== want) begin
            miscompares++;
            $display("FAIL %s data: got %h, want %h", nm, data, want);
        end
        rd = 1'b0;
        #1;
        vectors++;
        if (!bus_free()) begin
            miscompares++;
            $display("FAIL %s gate: data=%h with rd=0, want released", nm, data);
        end
        step();
        vectors++;
        if (data_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL %s oe_drop: data_oe=%b, want 0", nm, data_oe);
        end
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [7:0] first, input logic [7:0] last, input int ncyc);
        addr     = a;
        wr       = 1'b1;
        drv_en   = 1'b1;
        drv_data = first;
        for (int i = 0; i < ncyc; i++) begin
            if (i == ncyc - 1) drv_data = last;
            step();
        end
        wr     = 1'b0;
        drv_en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        vectors++;
        if (data_oe !== 1'b0 || ld_ack !== 1'b0 || rom_wr_err !== 1'b0 || halt_cycles !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: oe=%b ack=%b err=%b halt=%h, want 0 0 0 0000",
                     data_oe, ld_ack, rom_wr_err, halt_cycles);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_rom_load();
        addr     = 13'h1030;
        wr       = 1'b1;
        drv_en   = 1'b1;
        drv_data = 8'h99;
        ld_en    = 1'b1;
        ld_addr  = 8'h05;
        ld_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (ld_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL load_holdoff: ld_ack=%b during write, want 0", ld_ack);
            end
        end
        wr     = 1'b0;
        drv_en = 1'b0;
        step();
        vectors++;
        if (ld_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL load_ack: ld_ack=%b, want 1", ld_ack);
        end
        ld_en = 1'b0;
        step();
        vectors++;
        if (ld_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL load_ack_pulse: ld_ack=%b, want 0", ld_ack);
        end
        ld_en   = 1'b1;
        ld_addr = 8'h02;
        ld_data = 8'h5A;
        step();
        vectors++;
        if (ld_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL load2_ack: ld_ack=%b, want 1", ld_ack);
        end
        ld_en = 1'b0;
        step();
        cpu_read(13'h0005, 8'hA5, "rom_05");
        cpu_read(13'h0105, 8'h00, "rom_oob");
    endtask

    task automatic test_ram_write();
        cpu_write(13'h1010, 8'h11, 8'h3C, 3);
        vectors++;
        if (rom_wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ram_no_err: rom_wr_err=%b, want 0", rom_wr_err);
        end
        cpu_read(13'h1010, 8'h3C, "ram_1010");
        cpu_read(13'h1110, 8'h3C, "ram_alias");
        cpu_read(13'h1030, 8'h99, "ram_1030");
    endtask

    task automatic test_rom_write();
        cpu_write(13'h0002, 8'h77, 8'h77, 1);
        vectors++;
        if (rom_wr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL rom_err_pulse: rom_wr_err=%b, want 1", rom_wr_err);
        end
        step();
        vectors++;
        if (rom_wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rom_err_single: rom_wr_err=%b, want 0", rom_wr_err);
        end
        cpu_read(13'h0002, 8'h5A, "rom_02_kept");
        cpu_read(13'h1FFF, 8'h01, "status_err1");
    endtask

    task automatic test_conflict();
        addr     = 13'h1020;
        rd       = 1'b1;
        wr       = 1'b1;
        drv_en   = 1'b1;
        drv_data = 8'h55;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (data_oe !== 1'b0) begin
                miscompares++;
                $display("FAIL conflict_oe: data_oe=%b in cycle %0d, want 0", data_oe, i);
            end
        end
        rd     = 1'b0;
        wr     = 1'b0;
        drv_en = 1'b0;
        step();
        cpu_read(13'h1FFF, 8'h02, "status_err2");
        cpu_read(13'h1020, 8'h55, "conflict_commit");
        cpu_write(13'h1FFF, 8'h00, 8'h00, 1);
        cpu_read(13'h1FFF, 8'h00, "status_clear");
    endtask

    task automatic test_relaunch();
        int n;
        logic [7:0] want;
        exp_q.push_back(8'h3C);
        addr = 13'h1010;
        rd   = 1'b1;
        n    = 0;
        do begin step(); n++; end while (data_oe !== 1'b1 && n < READ_LAT + 4);
        want = exp_q.pop_front();
        vectors++;
        if (data_oe !== 1'b1 || data !== want) begin
            miscompares++;
            $display("FAIL relaunch_first: oe=%b data=%h, want 1 %h", data_oe, data, want);
        end
        exp_q.push_back(8'h99);
        addr = 13'h1030;
        step();
        vectors++;
        if (data_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL relaunch_drop: data_oe=%b, want 0", data_oe);
        end
        n = 0;
        do begin step(); n++; end while (data_oe !== 1'b1 && n < READ_LAT + 4);
        want = exp_q.pop_front();
        vectors++;
        if (n != READ_LAT || data !== want) begin
            miscompares++;
            $display("FAIL relaunch_second: %0d cycles data=%h, want %0d %h", n, data, READ_LAT, want);
        end
        rd = 1'b0;
        step();
    endtask

    task automatic test_halt();
        halt = 1'b1;
        repeat (10) step();
        halt = 1'b0;
        vectors++;
        if (halt_cycles !== 16'd10) begin
            miscompares++;
            $display("FAIL halt_count: got %0d, want 10", halt_cycles);
        end
        cpu_read(13'h1FFF, 8'h80, "status_halt");
        halt = 1'b1;
        repeat (65524) step();
        vectors++;
        if (halt_cycles !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL halt_near_max: got %h, want fffe", halt_cycles);
        end
        repeat (6) step();
        halt = 1'b0;
        vectors++;
        if (halt_cycles !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL halt_saturate: got %h, want ffff", halt_cycles);
        end
    endtask

    task automatic test_reset_in_drive();
        int n;
        logic [7:0] want;
        exp_q.push_back(8'h3C);
        addr = 13'h1010;
        rd   = 1'b1;
        n    = 0;
        do begin step(); n++; end while (data_oe !== 1'b1 && n < READ_LAT + 4);
        want = exp_q.pop_front();
        vectors++;
        if (data_oe !== 1'b1 || data !== want) begin
            miscompares++;
            $display("FAIL drive_before_reset: oe=%b data=%h, want 1 %h", data_oe, data, want);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (data_oe !== 1'b0 || !bus_free() || halt_cycles !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: oe=%b data=%h halt=%h, want 0 released 0000", data_oe, data, halt_cycles);
        end
        step();
        reset = 1'b1;
        rd    = 1'b0;
        step();
        cpu_read(13'h1FFF, 8'h00, "status_after_reset");
        cpu_read(13'h1010, 8'h3C, "ram_after_reset");
    endtask

    initial begin
        test_reset();
        test_rom_load();
        test_ram_write();
        test_rom_write();
        test_conflict();
        test_relaunch();
        test_halt();
        test_reset_in_drive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_mem_resp.md
Name: cpu_mem_resp

Overview:
- Memory-side responder for the CPU bus: answers CPU rd/wr strobes on the 13-bit address / 8-bit bidirectional data bus.
- Holds a ROM region (loaded through a side port), a RAM region and one status register.
- Drives the shared data bus only during a completed read.
- Also monitors the CPU halt line for debug.

Parameters:
- ROM_AW, 8, ROM address width; 2^ROM_AW bytes mapped from 0x0000.
- RAM_AW, 8, RAM address width; 2^RAM_AW bytes mapped from 0x1000.
- READ_LAT, 1, cycles from read launch to data drive; legal range 1..3.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd  in  1  CPU read strobe, level.
- wr  in  1  CPU write strobe, level.
- addr  in  13  CPU address.
- data  inout  8  shared data bus; driven only when data_oe=1, else high-Z.
- halt  in  1  CPU halt indication.
- ld_en  in  1  ROM load write enable.
- ld_addr  in  ROM_AW  ROM load address.
- ld_data  in  8  ROM load data.
- ld_ack  out  1  one-cycle pulse: load accepted.
- data_oe  out  1  bus drive enable (also debug).
- rom_wr_err  out  1  one-cycle pulse: CPU write to ROM region discarded.
- halt_cycles  out  16  count of cycles with halt=1.

Behaviour:
- Memory map:
  - addr[12]=0: ROM. Offsets at or above 2^ROM_AW read 0x00.
  - addr[12]=1 and addr!=0x1FFF: RAM at offset addr[RAM_AW-1:0]. Upper bits are ignored (aliasing).
  - addr=0x1FFF: STATUS = {halt_seen, err_cnt[6:0]}.
- Reset (reset=0, asynchronous): data_oe=0 (bus released immediately), ld_ack=0, rom_wr_err=0, halt_cycles=0, err_cnt=0, halt_seen=0, read FSM to IDLE. ROM/RAM contents are retained.
- Read FSM, states IDLE, WAIT, DRIVE:
  - IDLE→WAIT on rd=1 & wr=0 & rd_q=0 (rising edge). Latch addr, load lat_cnt=READ_LAT-1.
  - WAIT: decrement lat_cnt. At 0, register read data and enter DRIVE; data_oe=1 from the next edge.
  - Latency: rd seen high at edge N gives data valid on bus after edge N+READ_LAT.
  - DRIVE: hold data until rd=0, then go to IDLE with data_oe=0 at that edge. The bus is also combinationally gated: data is driven only when data_oe & rd.
  - From WAIT or DRIVE, if rd=1 and addr differs from the latched address: drop data_oe, relaunch to WAIT with the new address.
- Write:
  - While wr=1, sample addr and data every cycle.
  - On wr falling edge (wr_q=1, wr=0), commit the last sample:
    - RAM: byte stored.
    - ROM: discarded; rom_wr_err pulses 1 cycle; err_cnt+1.
    - STATUS: any value clears err_cnt and halt_seen.
- rd=1 & wr=1 together is a protocol conflict:
  - Read FSM forced to IDLE, no bus drive.
  - err_cnt+1 once, on the first conflict cycle only.
  - The write still commits on the wr falling edge.
- err_cnt saturates at 127.
- Simultaneous err_cnt increment and STATUS-clear in the same cycle: the clear wins.
- ROM load:
  - Accepted when ld_en=1 and rd=0 and wr=0. Writes ld_data to ld_addr; ld_ack pulses the next cycle.
  - With ld_en=1 during CPU activity: held off, no ack. Requester keeps ld_en high until ld_ack.
- Halt monitor:
  - halt_cycles increments each cycle halt=1, saturating at 0xFFFF.
  - halt_seen set on any halt=1; sticky until STATUS write or reset.

Test Plan:
- Load ROM[0x05]=0xA5 via ld_en, then CPU rd addr=0x0005 with READ_LAT=2 -> ld_ack pulses once. data=Z for 2 cycles, then 0xA5, Z again in the cycle after rd falls.
- Write 0x3C to 0x1010 (wr held 3 cycles, data changes 0x11→0x3C on last cycle), then read 0x1010 -> reads 0x3C. Alias 0x1110 with RAM_AW=8 also reads 0x3C.
- Write 0x77 to 0x0002 -> rom_wr_err single pulse; ROM[2] unchanged. Read 0x1FFF returns 0x01.
- Assert rd=1 and wr=1 together for 4 cycles -> data never driven; err_cnt +1 exactly. Then write 0x00 to 0x1FFF -> STATUS reads 0x00.
- halt=1 for 10 cycles, then read 0x1FFF -> halt_cycles=10, STATUS bit7=1. Force halt_cycles near 0xFFFF -> holds at 0xFFFF.
- Assert reset=0 while in DRIVE -> data goes Z asynchronously; counters cleared. Previously written RAM byte still reads back after reset release.
